// File: rtl/oflow_fetch_pkg.sv
// Shared types for the previous-frame feature fetch path.
package oflow_fetch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLd,
    StStart,
    StRun,
    StFin
  } fetch_st_t;

  // Line counts need one extra bit so a full memory (2^addr_w lines) is representable.
  function automatic int unsigned cnt_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/oflow_line_prefetch.sv
// Single-entry line buffer; data_o forwards data_i when the buffer is empty.
module oflow_line_prefetch #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q;
  logic [DATA_W-1:0] buf_q;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      full_q <= 1'b0;
      buf_q  <= '0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
      buf_q  <= data_i;
    end
  end

  assign full_o = full_q;
  assign data_o = full_q ? buf_q : data_i;

endmodule

// File: rtl/oflow_prev_feature_fetch.sv
// Streams previous-frame feature lines to the similarity PE, prefetching on the PE hint.
`ifndef DATA_TO_PE_WIDTH
`define DATA_TO_PE_WIDTH 32
`endif

module oflow_prev_feature_fetch
  import oflow_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = `DATA_TO_PE_WIDTH,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              start_frame,
  input  logic [ADDR_W:0]   num_lines,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] features_of_prev,
  output logic              pe_start,
  input  logic              control_for_read_new_line,
  input  logic              pe_valid,
  output logic [ADDR_W-1:0] line_idx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = cnt_w(ADDR_W);

  fetch_st_t         state_q, state_d;
  logic [ADDR_W-1:0] line_idx_q, line_idx_d;
  logic [CntW-1:0]   num_q, num_d;
  logic [DATA_W-1:0] feat_q, feat_d;
  logic              pend_q, pend_d;

  logic [CntW-1:0]   idx_next;
  logic              is_last;
  logic              run_valid;
  logic              hint_ok;
  logic              pf_full;
  logic              pf_load;
  logic [DATA_W-1:0] pf_data;

  assign idx_next  = {1'b0, line_idx_q} + CntW'(1);
  assign is_last   = (idx_next == num_q);
  assign run_valid = (state_q == StRun) && pe_valid;
  // pe_valid takes priority over a coincident hint; that path issues its own read.
  assign hint_ok   = (state_q == StRun) && control_for_read_new_line && !pe_valid &&
                     (idx_next < num_q) && !pf_full && !pend_q;
  assign pf_load   = pend_q && !run_valid;

  oflow_line_prefetch #(
    .DATA_W(DATA_W)
  ) u_prefetch (
    .clk    (clk),
    .reset_N(reset_N),
    .load_i (pf_load),
    .clear_i(run_valid),
    .data_i (mem_rd_data),
    .full_o (pf_full),
    .data_o (pf_data)
  );

  always_comb begin
    state_d    = state_q;
    line_idx_d = line_idx_q;
    num_d      = num_q;
    feat_d     = feat_q;
    pend_d     = hint_ok;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    unique case (state_q)
      StIdle: begin
        if (start_frame) begin
          num_d = num_lines;
          if (num_lines != '0) begin
            mem_rd_en  = 1'b1;
            line_idx_d = '0;
            state_d    = StLd;
          end else begin
            state_d = StFin;
          end
        end
      end
      StLd: begin
        feat_d  = mem_rd_data;
        state_d = StStart;
      end
      StStart: state_d = StRun;
      StRun: begin
        if (hint_ok) begin
          mem_rd_en = 1'b1;
          mem_addr  = idx_next[ADDR_W-1:0];
        end
        if (pe_valid) begin
          if (is_last) begin
            state_d = StFin;
          end else begin
            line_idx_d = idx_next[ADDR_W-1:0];
            if (pf_full || pend_q) begin
              feat_d  = pf_data;
              state_d = StStart;
            end else begin
              mem_rd_en = 1'b1;
              mem_addr  = idx_next[ADDR_W-1:0];
              state_d   = StLd;
            end
          end
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q    <= StIdle;
      line_idx_q <= '0;
      num_q      <= '0;
      feat_q     <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_idx_q <= line_idx_d;
      num_q      <= num_d;
      feat_q     <= feat_d;
      pend_q     <= pend_d;
    end
  end

  assign features_of_prev = feat_q;
  assign line_idx         = line_idx_q;
  assign pe_start         = (state_q == StStart);
  assign done             = (state_q == StFin);
  assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_oflow_prev_feature_fetch.sv
// Directed bench: memory and PE models around the fetch block, table of line-count scenarios.
module tb_oflow_prev_feature_fetch;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int          LAT = 9;

  logic          clk = 1'b0;
  logic          reset_N = 1'b0;
  logic          start_frame = 1'b0;
  logic [AW:0]   num_lines = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] features_of_prev;
  logic          pe_start;
  logic          control_for_read_new_line = 1'b0;
  logic          pe_valid = 1'b0;
  logic [AW-1:0] line_idx;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  oflow_prev_feature_fetch #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk                      (clk),
    .reset_N                  (reset_N),
    .start_frame              (start_frame),
    .num_lines                (num_lines),
    .mem_rd_en                (mem_rd_en),
    .mem_addr                 (mem_addr),
    .mem_rd_data              (mem_rd_data),
    .features_of_prev         (features_of_prev),
    .pe_start                 (pe_start),
    .control_for_read_new_line(control_for_read_new_line),
    .pe_valid                 (pe_valid),
    .line_idx                 (line_idx),
    .busy                     (busy),
    .done                     (done)
  );

  // hint: 0 = never, 1 = once 2 cycles before pe_valid, 2 = at 3 and 2 cycles before.
  // sf_cyc: cycle of a spurious start_frame (-1 for none).
  typedef struct {
    int n;
    int hint;
    int sf_cyc;
    int exp_reads;
    int exp_starts;
    int exp_first;
    int exp_done;
    int exp_gap;
    int exp_last;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   failures = 0;
  int   pe_cnt;
  logic rd_pend;
  logic [AW-1:0] rd_addr;

  function automatic logic [DW-1:0] data_of(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {8'hA5, b, 8'(b * 8'd17), 8'h5A};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int cyc, reads, starts, dones, done_cyc, last_valid, first_start;
    int stray, addr_bad, dstart_bad, dvalid_bad, idx_bad, gap_bad;
    int busy_at_done, busy_after;
    bit finished;
    string p;
    p = $sformatf("v%0d_", vi);
    reads = 0; starts = 0; dones = 0; done_cyc = -1; last_valid = 0; first_start = -1;
    stray = 0; addr_bad = 0; dstart_bad = 0; dvalid_bad = 0; idx_bad = 0; gap_bad = 0;
    busy_at_done = 0; busy_after = 1; finished = 1'b0;
    pe_cnt = 0; rd_pend = 1'b0; rd_addr = '0;
    for (cyc = 0; cyc < 2000 && !finished; cyc++) begin
      @(posedge clk); #1;
      start_frame = (cyc == 0) || (cyc == v.sf_cyc);
      num_lines   = (cyc == 0) ? 6'(v.n) : 6'd5;
      pe_valid    = (pe_cnt == 1);
      control_for_read_new_line = (v.hint >= 1 && pe_cnt == 3) || (v.hint == 2 && pe_cnt == 4);
      mem_rd_data = rd_pend ? data_of(int'(rd_addr)) : 32'hDEAD_BEEF;
      #1;
      if (mem_rd_en) begin
        if (int'(mem_addr) != reads) addr_bad++;
        reads++;
        if ((done || !busy) && cyc != 0) stray++;
      end
      if (pe_start) begin
        if (first_start < 0) first_start = cyc;
        else if (cyc - last_valid != v.exp_gap) gap_bad++;
        if (features_of_prev !== data_of(starts)) dstart_bad++;
        if (int'(line_idx) != starts) idx_bad++;
        starts++;
      end
      if (pe_valid) begin
        last_valid = cyc;
        if (features_of_prev !== data_of(starts - 1)) dvalid_bad++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        busy_at_done = int'(busy);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = int'(busy);
        finished = 1'b1;
      end
      rd_pend = mem_rd_en;
      rd_addr = mem_addr;
      if (pe_cnt > 0) pe_cnt--;
      if (pe_start) pe_cnt = LAT;
    end
    start_frame = 1'b0;
    pe_valid = 1'b0;
    control_for_read_new_line = 1'b0;
    check({p, "finished"}, int'(finished), 1);
    check({p, "reads"}, reads, v.exp_reads);
    check({p, "read_addr_seq"}, addr_bad, 0);
    check({p, "stray_read"}, stray, 0);
    check({p, "pe_starts"}, starts, v.exp_starts);
    check({p, "first_start_cyc"}, first_start, v.exp_first);
    check({p, "data_at_start"}, dstart_bad, 0);
    check({p, "data_at_valid"}, dvalid_bad, 0);
    check({p, "idx_at_start"}, idx_bad, 0);
    check({p, "restart_gap"}, gap_bad, 0);
    check({p, "done_count"}, dones, 1);
    check({p, "done_cyc"}, done_cyc, v.exp_done);
    check({p, "busy_at_done"}, busy_at_done, 1);
    check({p, "busy_after_done"}, busy_after, 0);
    check({p, "last_line_idx"}, int'(line_idx), v.exp_last);
  endtask

  initial begin
    int dones;
    //           n  hint sf  reads starts first done  gap last
    vecs[0] = '{ 1, 1,  -1,  1,    1,     2,    12,   0,  0};  // single line, hint on last line
    vecs[1] = '{ 4, 1,  -1,  4,    4,     2,    42,   1,  3};  // hint honoured
    vecs[2] = '{ 3, 0,  -1,  3,    3,     2,    34,   2,  2};  // hint missed
    vecs[3] = '{ 0, 1,  -1,  0,    0,    -1,     1,   0,  2};  // zero lines, idx held
    vecs[4] = '{32, 1,  -1, 32,   32,     2,   322,   1, 31};  // full memory
    vecs[5] = '{ 5, 2,  -1,  5,    5,     2,    52,   1,  4};  // repeated hint
    vecs[6] = '{ 2, 1,   5,  2,    2,     2,    22,   1,  1};  // start_frame during RUN
    vecs[7] = '{ 1, 1,  -1,  1,    1,     2,    12,   0,  0};  // fresh frame after reset

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_features", int'(features_of_prev != '0), 0);
    check("rst_pe_start", int'(pe_start), 0);
    reset_N = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort mid-RUN with reset.
    @(posedge clk); #1;
    start_frame = 1'b1;
    num_lines = 6'd3;
    @(posedge clk); #1;
    start_frame = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_abort_busy", int'(busy), 1);
    reset_N = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_pe_start", int'(pe_start), 0);
    check("abort_mem_rd_en", int'(mem_rd_en), 0);
    check("abort_features", int'(features_of_prev != '0), 0);
    check("abort_line_idx", int'(line_idx), 0);
    dones = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("abort_no_done", dones, 0);
    reset_N = 1'b1;

    run_vec(7, vecs[7]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
